gpu_sram_arbiter: RTL

Two-requester arbiter and sequencer for the single GPU-SRAM port. It sits between the GPU's screen-clear engine (requester 0) and line-draw engine (requester 1) and the SRAM interface signals (O_GPU_ADDR/DATA/READ/WRITE, I_GPU_DATA). Each cycle while I_VIDEO_ON is low, it grants at most one read or write. It enforces round-robin fairness and returns read data to the requester that issued the read.

---
 rtl/gpu_sram_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/gpu_sram_arbiter.sv
// gpu_sram_arbiter
//   Arbitrates the single GPU-SRAM port between the screen-clear engine
//   (requester 0) and the line-draw engine (requester 1). At most one read or
//   write is granted per cycle while the display is not scanning out. Both
//   requesters share the same arbitration for reads and writes. Read data is
//   returned to whichever requester issued the read.
//
// Parameters
//   ADDR_W    SRAM word address width
//   DATA_W    SRAM data width
//   READ_LAT  cycles from the read-strobe cycle to the I_GPU_DATA capture edge (1..7)
//
// Ports
//   I_CLK, I_RST_N             clock, async active-low reset
//   I_VIDEO_ON                 high = scan-out owns SRAM, no new grants
//   I_REQn/I_WEn/I_ADDRn/I_WDATAn  requester n: valid, write-enable, address, write data
//   O_ACKn                     combinational grant; transfer at edge with REQn & ACKn
//   O_RDATA, O_RVALIDn         read return data and per-requester valid pulse
//   I_GPU_DATA                 SRAM read data
//   O_GPU_ADDR/DATA/WRITE/READ registered SRAM address, write data and strobes
//
// Build option
//   GPU_ARB_FIXED_PRIO_EN  defined: requester 1 always wins ties (requester 0
//                          may starve). Undefined: round-robin on ties.
//
// States
//   S_IDLE  | grants allowed
//   S_RWAIT | read outstanding, grants blocked until the data is captured

module gpu_sram_arbiter #(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 1
) (
   input  logic              I_CLK,
   input  logic              I_RST_N,
   input  logic              I_VIDEO_ON,
   input  logic              I_REQ0,
   input  logic              I_REQ1,
   input  logic              I_WE0,
   input  logic              I_WE1,
   input  logic [ADDR_W-1:0] I_ADDR0,
   input  logic [ADDR_W-1:0] I_ADDR1,
   input  logic [DATA_W-1:0] I_WDATA0,
   input  logic [DATA_W-1:0] I_WDATA1,
   output logic              O_ACK0,
   output logic              O_ACK1,
   output logic [DATA_W-1:0] O_RDATA,
   output logic              O_RVALID0,
   output logic              O_RVALID1,
   input  logic [DATA_W-1:0] I_GPU_DATA,
   output logic [DATA_W-1:0] O_GPU_DATA,
   output logic [ADDR_W-1:0] O_GPU_ADDR,
   output logic              O_GPU_WRITE,
   output logic              O_GPU_READ
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_RWAIT = 1'b1
   } state_t;

   localparam logic [2:0] LAT = READ_LAT[2:0];

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_owner;
   logic [2:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_write;
   logic              r_read;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid0;
   logic              r_rvalid1;

   logic              w_elig0;
   logic              w_elig1;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_gnt_any;
   logic              w_gnt_we;
   logic              w_rd_done;

`ifndef GPU_ARB_FIXED_PRIO_EN
   // 1 = requester 1 preferred on the next tie
   logic              r_ptr;
`endif

   assign w_elig0   = (r_state == S_IDLE) && !I_VIDEO_ON && I_REQ0;
   assign w_elig1   = (r_state == S_IDLE) && !I_VIDEO_ON && I_REQ1;
   assign w_gnt_any = w_gnt0 | w_gnt1;
   assign w_gnt_we  = w_gnt1 ? I_WE1 : I_WE0;
   assign w_rd_done = (r_state == S_RWAIT) && (r_cnt == 3'd1);

   always_comb begin
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_state_nxt = r_state;

      if (w_elig0 && w_elig1) begin
`ifdef GPU_ARB_FIXED_PRIO_EN
         w_gnt1 = 1'b1;
`else
         w_gnt1 = r_ptr;
         w_gnt0 = !r_ptr;
`endif
      end else begin
         w_gnt0 = w_elig0;
         w_gnt1 = w_elig1;
      end

      case (r_state)
         S_IDLE:  if (w_gnt_any && !w_gnt_we) w_state_nxt = S_RWAIT;
         S_RWAIT: if (w_rd_done)             w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

`ifndef GPU_ARB_FIXED_PRIO_EN
   // After a grant to requester n the preference moves to the other one,
   // including when n was the only requester.
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         r_ptr <= 1'b1;
      end else if (w_gnt_any) begin
         r_ptr <= w_gnt0;
      end
   end
`endif

   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         r_owner   <= 1'b0;
         r_cnt     <= 3'd0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_write   <= 1'b0;
         r_read    <= 1'b0;
         r_rdata   <= '0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_write   <= 1'b0;
         r_read    <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;

         if (w_gnt_any) begin
            r_addr <= w_gnt1 ? I_ADDR1 : I_ADDR0;
            if (w_gnt_we) begin
               r_wdata <= w_gnt1 ? I_WDATA1 : I_WDATA0;
               r_write <= 1'b1;
            end else begin
               r_read  <= 1'b1;
               r_owner <= w_gnt1;
               r_cnt   <= LAT;
            end
         end

         // Grants only happen in S_IDLE, so this never collides with the load above.
         if (r_state == S_RWAIT) begin
            r_cnt <= r_cnt - 3'd1;
            if (w_rd_done) begin
               r_rdata   <= I_GPU_DATA;
               r_rvalid0 <= !r_owner;
               r_rvalid1 <= r_owner;
            end
         end
      end
   end

   // Gated by reset so a request held through reset is never acknowledged.
   assign O_ACK0      = w_gnt0 & I_RST_N;
   assign O_ACK1      = w_gnt1 & I_RST_N;
   assign O_RDATA     = r_rdata;
   assign O_RVALID0   = r_rvalid0;
   assign O_RVALID1   = r_rvalid1;
   assign O_GPU_DATA  = r_wdata;
   assign O_GPU_ADDR  = r_addr;
   assign O_GPU_WRITE = r_write;
   assign O_GPU_READ  = r_read;

endmodule
